// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side instruction bundle into the issue stage and the
// ID/EX pipeline register contents it presents to the ALU.
// Ports: id_* fields and id_stall (decode side); ex_* fields (EX side).
// master = decode/ALU environment, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  // Decode side
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [RAW-1:0]  id_rs1;
  logic [RAW-1:0]  id_rs2;
  logic            id_use_rs2;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [RAW-1:0]  id_rd;
  logic            id_rd_we;
  logic            id_is_load;
  logic            id_stall;
  // EX register contents
  logic            ex_valid;
  logic [6:0]      ex_opcode;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_store_data;
  logic [RAW-1:0]  ex_rd;
  logic            ex_rd_we;
  logic            ex_is_load;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_use_rs2, id_imm,
           id_rs1_data, id_rs2_data, id_rd, id_rd_we, id_is_load,
    input  id_stall, ex_valid, ex_opcode, ex_a, ex_b, ex_store_data,
           ex_rd, ex_rd_we, ex_is_load
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_use_rs2, id_imm,
           id_rs1_data, id_rs2_data, id_rd, id_rd_we, id_is_load,
    output id_stall, ex_valid, ex_opcode, ex_a, ex_b, ex_store_data,
           ex_rd, ex_rd_we, ex_is_load
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: issue stage ahead of the ALU. Bypasses operands from EX/MEM/WB,
// stalls decode one cycle on a load-use hazard and registers the ID/EX pipeline
// register (1-cycle latency). ex_hold freezes EX and stalls decode; flush inserts a bubble.
// Ports: clk, rst_n (sync, active-low); bus (id_* in, id_stall/ex_* out);
// alu_result, mem_rd/mem_we/mem_data, wb_rd/wb_we/wb_data bypass sources;
// ex_hold, flush controls; stall_count saturating load-use bubble counter.
module id_ex_stage #(
  parameter int         XLEN      = 32,
  parameter int         RAW       = 5,
  parameter logic [6:0] BUBBLE_OP = 7'h7F
) (
  input  logic            clk,
  input  logic            rst_n,
  id_ex_stage_if.slave    bus,
  input  logic [XLEN-1:0] alu_result,
  input  logic [RAW-1:0]  mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [RAW-1:0]  wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_hold,
  input  logic            flush,
  output logic [31:0]     stall_count
);

  logic            ex_valid_q;
  logic [6:0]      ex_opcode_q;
  logic [XLEN-1:0] ex_a_q;
  logic [XLEN-1:0] ex_b_q;
  logic [XLEN-1:0] ex_store_data_q;
  logic [RAW-1:0]  ex_rd_q;
  logic            ex_rd_we_q;
  logic            ex_is_load_q;
  logic [31:0]     stall_cnt_q;

  logic            ex_fwd_ok;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            load_use;
  logic            bubble;
  logic            capture;
  logic            count_up;

  // A load in EX has no result yet, so it never forwards from EX; that case
  // is covered by the load-use stall and the MEM bypass one cycle later.
  function automatic logic [XLEN-1:0] bypass(input logic [RAW-1:0]  r,
                                             input logic [XLEN-1:0] d);
    logic [XLEN-1:0] v;
    if (r == '0)                                v = '0;
    else if (ex_fwd_ok && ex_rd_q == r)         v = alu_result;
    else if (mem_we && mem_rd == r)             v = mem_data;
    else if (wb_we && wb_rd == r)               v = wb_data;
    else                                        v = d;
    return v;
  endfunction

  always_comb begin
    ex_fwd_ok = ex_valid_q & ex_rd_we_q & ~ex_is_load_q;
    rs1_val   = bypass(bus.id_rs1, bus.id_rs1_data);
    rs2_val   = bypass(bus.id_rs2, bus.id_rs2_data);
    load_use  = bus.id_valid & ex_valid_q & ex_is_load_q & ex_rd_we_q &
                (ex_rd_q != '0) &
                ((ex_rd_q == bus.id_rs1) | (bus.id_use_rs2 & (ex_rd_q == bus.id_rs2)));
    // flush outranks ex_hold, which outranks load_use and the normal load.
    bubble    = flush | (~ex_hold & (load_use | ~bus.id_valid));
    capture   = ~flush & ~ex_hold & ~load_use & bus.id_valid;
    count_up  = ~flush & ~ex_hold & load_use & (stall_cnt_q != 32'hFFFF_FFFF);
  end

  assign bus.id_stall = rst_n & ~flush & (ex_hold | load_use);

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      ex_valid_q      <= 1'b0;
      ex_opcode_q     <= BUBBLE_OP;
      ex_a_q          <= '0;
      ex_b_q          <= '0;
      ex_store_data_q <= '0;
      ex_rd_q         <= '0;
      ex_rd_we_q      <= 1'b0;
      ex_is_load_q    <= 1'b0;
    end else if (capture) begin
      ex_valid_q      <= 1'b1;
      ex_opcode_q     <= bus.id_opcode;
      ex_a_q          <= rs1_val;
      ex_b_q          <= bus.id_use_rs2 ? rs2_val : bus.id_imm;
      ex_store_data_q <= rs2_val;
      ex_rd_q         <= bus.id_rd;
      ex_rd_we_q      <= bus.id_rd_we;
      ex_is_load_q    <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        stall_cnt_q <= '0;
    else if (count_up) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_opcode     = ex_opcode_q;
  assign bus.ex_a          = ex_a_q;
  assign bus.ex_b          = ex_b_q;
  assign bus.ex_store_data = ex_store_data_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_rd_we      = ex_rd_we_q;
  assign bus.ex_is_load    = ex_is_load_q;
  assign stall_count       = stall_cnt_q;

endmodule
